// File: rtl/direction_input.sv
// direction_input: debounced active-low buttons -> one-cold Snake direction, committed on update.
// Define REVERSE_BLOCK_EN to discard candidates that would reverse the snake onto itself.
module direction_input #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W = 18
) (
    input  logic VGA_clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_left,
    input  logic btn_down,
    input  logic btn_right,
    input  logic update,
    output logic up,
    output logic left,
    output logic down,
    output logic right,
    output logic committed
);
    typedef enum logic {IDLE, MOVING} state_t;
    state_t state, state_n;
    logic [3:0] raw, sync1, sync2, stable, ev, press, cand, opp;
    logic [3:0] pending, pending_n, dir, dir_n;
    logic [CNT_W-1:0] cnt [4];
    logic committed_n, blocked;
    assign raw = {btn_right, btn_down, btn_left, btn_up};
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            stable <= '1;
            for (int k = 0; k < 4; k++) cnt[k] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int k = 0; k < 4; k++) begin
                if (sync2[k] == stable[k]) cnt[k] <= '0;
                else if (cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[k] <= sync2[k];
                    cnt[k] <= '0;
                end else cnt[k] <= cnt[k] + CNT_W'(1);
            end
        end
    end
    // A press is the cycle in which a debounced level is about to fall to 0
    genvar i;
    for (i = 0; i < 4; i++) begin : g_ev
        assign ev[i] = stable[i] & ~sync2[i] & (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
    end
    assign press = ev[0] ? 4'b0001 : ev[1] ? 4'b0010 : ev[2] ? 4'b0100 : ev[3] ? 4'b1000 : 4'b0000;
    assign cand = |press ? press : pending;
    assign opp = {dir[1], dir[0], dir[3], dir[2]};
`ifdef REVERSE_BLOCK_EN
    assign blocked = (cand == opp);
`else
    assign blocked = 1'b0;
`endif
    always_comb begin
        state_n = state;
        dir_n = dir;
        pending_n = |press ? press : pending;
        committed_n = 1'b0;
        if (update && |cand) begin
            pending_n = '0;
            if (state == IDLE) begin
                state_n = MOVING;
                dir_n = cand;
                committed_n = 1'b1;
            end else if (cand != dir && !blocked) begin
                dir_n = cand;
                committed_n = 1'b1;
            end
        end
    end
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            dir <= '0;
            pending <= '0;
            committed <= 1'b0;
        end else begin
            state <= state_n;
            dir <= dir_n;
            pending <= pending_n;
            committed <= committed_n;
        end
    end
    assign {right, down, left, up} = ~dir;
endmodule

// File: tb/tb_direction_input.sv
// tb_direction_input: randomized and directed checks against a button-level direction model.
module tb_direction_input;
    logic VGA_clk = 1'b0;
    logic reset = 1'b1;
    logic update = 1'b0;
    logic [3:0] btn = 4'hF;
    logic up, left, down, right, committed;
    int checks = 0;
    int errors = 0;
    int m_dir = -1;
    int m_pend = -1;
    logic m_com;
    logic [3:0] o_dir;
    logic o_com, o_com2;

    always #20 VGA_clk = ~VGA_clk;

    direction_input #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .VGA_clk(VGA_clk), .reset(reset),
        .btn_up(btn[0]), .btn_left(btn[1]), .btn_down(btn[2]), .btn_right(btn[3]),
        .update(update),
        .up(up), .left(left), .down(down), .right(right),
        .committed(committed)
    );

    function automatic logic [3:0] exp_out();
        logic [3:0] v;
        v = 4'hF;
        if (m_dir >= 0) v[m_dir] = 1'b0;
        return v;
    endfunction

    function automatic int lowest(input logic [3:0] m);
        for (int k = 0; k < 4; k++) if (m[k]) return k;
        return -1;
    endfunction

    task automatic hold(input logic [3:0] mask, input int n);
        btn = ~mask;
        repeat (n) @(negedge VGA_clk);
        btn = 4'hF;
        repeat (10) @(negedge VGA_clk);
    endtask

    task automatic press(input logic [3:0] mask);
        hold(mask, 10);
        if (mask != 0) m_pend = lowest(mask);
    endtask

    task automatic pulse_update();
        logic blk;
`ifdef REVERSE_BLOCK_EN
        blk = (m_dir >= 0) && (m_pend == (m_dir + 2) % 4);
`else
        blk = 1'b0;
`endif
        m_com = 1'b0;
        if (m_pend >= 0) begin
            if (m_dir < 0 || (m_pend != m_dir && !blk)) begin
                m_dir = m_pend;
                m_com = 1'b1;
            end
            m_pend = -1;
        end
        update = 1'b1;
        @(negedge VGA_clk);
        update = 1'b0;
        o_dir = {right, down, left, up};
        o_com = committed;
        @(negedge VGA_clk);
        o_com2 = committed;
    endtask

    task automatic test_reset();
        checks++;
        if ({right, down, left, up} !== 4'hF || committed !== 1'b0) begin
            errors++;
            $display("FAIL reset_state dir=%b com=%b expected 1111/0", {right, down, left, up}, committed);
        end
        for (int n = 0; n < 3; n++) begin
            pulse_update();
            checks++;
            if (o_dir !== 4'hF || o_com !== 1'b0 || o_com2 !== 1'b0) begin
                errors++;
                $display("FAIL idle_update%0d dir=%b com=%b/%b expected 1111/0/0", n, o_dir, o_com, o_com2);
            end
        end
    endtask

    task automatic test_glitch();
        hold(4'b1000, 2);
        pulse_update();
        checks++;
        if (o_dir !== 4'hF || o_com !== 1'b0) begin
            errors++;
            $display("FAIL glitch dir=%b com=%b expected 1111/0", o_dir, o_com);
        end
    endtask

    task automatic test_first_press();
        press(4'b0001);
        checks++;
        if ({right, down, left, up} !== 4'hF) begin
            errors++;
            $display("FAIL no_update_hold dir=%b expected 1111", {right, down, left, up});
        end
        pulse_update();
        checks++;
        if (o_dir !== 4'b1110 || o_com !== 1'b1 || o_com2 !== 1'b0) begin
            errors++;
            $display("FAIL first_press dir=%b com=%b/%b expected 1110/1/0", o_dir, o_com, o_com2);
        end
    endtask

    task automatic test_last_wins();
        press(4'b0010);
        press(4'b0100);
        pulse_update();
        checks++;
        if (o_dir !== 4'b1011 || o_com !== 1'b1) begin
            errors++;
            $display("FAIL last_wins dir=%b com=%b expected 1011/1", o_dir, o_com);
        end
    endtask

    task automatic test_reverse();
        press(4'b1000);
        pulse_update();
        checks++;
        if (o_dir !== 4'b0111 || o_com !== 1'b1) begin
            errors++;
            $display("FAIL to_right dir=%b com=%b expected 0111/1", o_dir, o_com);
        end
        press(4'b0010);
        pulse_update();
        checks++;
`ifdef REVERSE_BLOCK_EN
        if (o_dir !== 4'b0111 || o_com !== 1'b0) begin
            errors++;
            $display("FAIL reverse dir=%b com=%b expected 0111/0", o_dir, o_com);
        end
`else
        if (o_dir !== 4'b1101 || o_com !== 1'b1) begin
            errors++;
            $display("FAIL reverse dir=%b com=%b expected 1101/1", o_dir, o_com);
        end
`endif
    endtask

    task automatic test_priority();
        press(4'b0011);
        pulse_update();
        checks++;
        if (o_dir !== 4'b1110 || o_com !== 1'b1) begin
            errors++;
            $display("FAIL priority dir=%b com=%b expected 1110/1", o_dir, o_com);
        end
        press(4'b0001);
        pulse_update();
        checks++;
        if (o_dir !== 4'b1110 || o_com !== 1'b0) begin
            errors++;
            $display("FAIL same_dir dir=%b com=%b expected 1110/0", o_dir, o_com);
        end
        pulse_update();
        checks++;
        if (o_dir !== 4'b1110 || o_com !== 1'b0) begin
            errors++;
            $display("FAIL pending_cleared dir=%b com=%b expected 1110/0", o_dir, o_com);
        end
    endtask

    task automatic test_reset_mid_hold();
        press(4'b1000);
        pulse_update();
        btn = 4'b1110;
        repeat (4) @(negedge VGA_clk);
        #5 reset = 1'b1;
        #1;
        m_dir = -1;
        m_pend = -1;
        checks++;
        if ({right, down, left, up} !== 4'hF || committed !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold dir=%b com=%b expected 1111/0", {right, down, left, up}, committed);
        end
        @(negedge VGA_clk);
        reset = 1'b0;
        repeat (10) @(negedge VGA_clk);
        m_pend = 0;
        btn = 4'hF;
        repeat (10) @(negedge VGA_clk);
        pulse_update();
        checks++;
        if (o_dir !== 4'b1110 || o_com !== 1'b1) begin
            errors++;
            $display("FAIL held_through_reset dir=%b com=%b expected 1110/1", o_dir, o_com);
        end
        press(4'b0010);
        reset = 1'b1;
        @(negedge VGA_clk);
        reset = 1'b0;
        m_dir = -1;
        m_pend = -1;
        pulse_update();
        checks++;
        if (o_dir !== 4'hF || o_com !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending dir=%b com=%b expected 1111/0", o_dir, o_com);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: press(4'b1 << $urandom_range(0, 3));
                1: press(4'($urandom_range(1, 15)));
                2: hold(4'($urandom_range(1, 15)), 2);
                default: begin
                    pulse_update();
                    checks++;
                    if (o_dir !== exp_out() || o_com !== m_com || o_com2 !== 1'b0) begin
                        errors++;
                        $display("FAIL random%0d dir=%b com=%b/%b expected %b/%b/0", n, o_dir, o_com, o_com2, exp_out(), m_com);
                    end
                end
            endcase
            checks++;
            if ({right, down, left, up} !== exp_out()) begin
                errors++;
                $display("FAIL random_hold%0d dir=%b expected %b", n, {right, down, left, up}, exp_out());
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge VGA_clk);
        reset = 1'b0;
        @(negedge VGA_clk);
        test_reset();
        test_glitch();
        test_first_press();
        test_last_wins();
        test_reverse();
        test_priority();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
